// File: rtl/block_ram_arbiter_pkg.sv
// Shared TileLink-UL types plus the two-host block_ram arbiter state and opcode constants.
package block_ram_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  a_opcode;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_valid;
    } tilelink_a;

    typedef struct packed {
        logic [2:0]  d_opcode;
        logic [31:0] d_data;
        logic        d_error;
        logic        d_valid;
        logic        d_ready;
    } tilelink_d;

    localparam logic [2:0] TlPutFullData    = 3'd0;
    localparam logic [2:0] TlPutPartialData = 3'd1;
    localparam logic [2:0] TlGet            = 3'd4;
    localparam logic [2:0] TlAccessAck      = 3'd0;
    localparam logic [2:0] TlAccessAckData  = 3'd1;

    typedef enum logic {
        ArbIdle = 1'b0,
        ArbBusy = 1'b1
    } arb_state_e;

endpackage

// File: rtl/block_ram_arbiter_pick2.sv
// Combinational two-way round-robin pick: on contention the host that did not win last time wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/block_ram_arbiter.sv
// Shares one block_ram TL-UL port between fetch (host 0) and load/store (host 1), one
// transaction outstanding, with a timeout that synthesises an error response on tag misses.
module block_ram_arbiter
    import block_ram_arbiter_pkg::*;
#(
    parameter int unsigned Timeout = 16
) (
    input  logic      clock,
    input  logic      reset,
    input  tilelink_a host0_tla,
    output tilelink_d host0_tld,
    input  tilelink_a host1_tla,
    output tilelink_d host1_tld,
    output tilelink_a mem_tla,
    input  tilelink_d mem_tld
);

    localparam logic [7:0] TcountLast = 8'(Timeout - 1);

    arb_state_e r_state;
    logic       r_owner;
    logic       r_last_grant;
    logic [7:0] r_tcount;

    logic       w_busy;
    logic       w_resp;
    logic       w_timeout;
    logic       w_window;
    logic       w_accept;
    logic       w_gnt_idx;
    logic [1:0] w_req;
    logic [1:0] w_gnt;
    tilelink_a  w_sel_tla;
    tilelink_d  w_route;
    logic       w_unused_ready;

    assign w_busy    = (r_state == ArbBusy);
    assign w_resp    = w_busy && mem_tld.d_valid;
    assign w_timeout = w_busy && !mem_tld.d_valid && (r_tcount == TcountLast);
    // A response arriving this cycle frees the RAM, so the next request may issue back-to-back.
    assign w_window  = !reset && (!w_busy || mem_tld.d_valid);
    assign w_req     = {host1_tla.a_valid, host0_tla.a_valid} & {2{w_window}};

    rr_pick2 u_pick (
        .req  (w_req),
        .last (r_last_grant),
        .gnt  (w_gnt)
    );

    assign w_accept       = |w_gnt;
    assign w_gnt_idx      = w_gnt[1];
    assign w_sel_tla      = w_gnt_idx ? host1_tla : host0_tla;
    assign w_unused_ready = mem_tld.d_ready;

    always_comb begin
        w_route = '0;
        if (!reset) begin
            if (w_resp) begin
                w_route.d_opcode = mem_tld.d_opcode;
                w_route.d_data   = mem_tld.d_data;
                w_route.d_error  = mem_tld.d_error;
                w_route.d_valid  = 1'b1;
            end else if (w_timeout) begin
                w_route.d_opcode = TlAccessAckData;
                w_route.d_data   = 32'h0;
                w_route.d_error  = 1'b1;
                w_route.d_valid  = 1'b1;
            end
        end
    end

    always_comb begin
        host0_tld = '0;
        host1_tld = '0;
        if (r_owner) begin
            host1_tld = w_route;
        end else begin
            host0_tld = w_route;
        end
        host0_tld.d_ready = w_gnt[0];
        host1_tld.d_ready = w_gnt[1];
        mem_tla         = 'x;
        mem_tla.a_valid = 1'b0;
        if (w_accept) begin
            mem_tla         = w_sel_tla;
            mem_tla.a_valid = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ArbIdle;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_tcount     <= 8'd0;
        end else if (w_accept) begin
            r_state      <= ArbBusy;
            r_owner      <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_tcount     <= 8'd0;
        end else if (w_resp || w_timeout) begin
            r_state  <= ArbIdle;
            r_tcount <= 8'd0;
        end else if (w_busy) begin
            r_tcount <= r_tcount + 8'd1;
        end
    end

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Bench for block_ram_arbiter: stub RAM with hit/slow/miss address regions, a behavioural
// reference model checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_block_ram_arbiter;
    import block_ram_arbiter_pkg::*;

    localparam int unsigned Tmo = 16;

    logic      clock = 1'b0;
    logic      reset = 1'b1;
    tilelink_a h0_a;
    tilelink_a h1_a;
    tilelink_a mem_a;
    tilelink_d h0_d;
    tilelink_d h1_d;
    tilelink_d mem_d;

    int n_checks = 0;
    int n_errors = 0;

    block_ram_arbiter #(.Timeout(Tmo)) dut (
        .clock     (clock),
        .reset     (reset),
        .host0_tla (h0_a),
        .host0_tld (h0_d),
        .host1_tla (h1_a),
        .host1_tld (h1_d),
        .mem_tla   (mem_a),
        .mem_tld   (mem_d)
    );

    always #5 clock = ~clock;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [5:0] i);
        if (i == 6'd4) return 32'hDEADBEEF;
        if (i == 6'd8) return 32'h11223344;
        return (32'h01010101 * {26'd0, i}) ^ 32'h5A000000;
    endfunction

    // 0: RAM hit (1-cycle answer), 1: slow region (answers after Tmo cycles), 2: miss
    function automatic int kind(input logic [31:0] a);
        if (a[31:8] == 24'd0) return 0;
        if (a[31:28] == 4'h8) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input tilelink_a t);
        logic [31:0] m;
        logic [31:0] sh;
        if (t.a_opcode == TlGet) return old;
        sh = t.a_data << {t.a_address[1:0], 3'b000};
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{t.a_mask[b]}};
        return (old & ~m) | (sh & m);
    endfunction

    function automatic tilelink_a mk(input logic [2:0] op, input logic [31:0] addr,
                                     input logic [3:0] mask, input logic [31:0] data);
        return '{a_opcode: op, a_address: addr, a_mask: mask, a_data: data, a_valid: 1'b1};
    endfunction

    // Stub block_ram: captures the accepted request, answers on the following cycle (or later)
    logic [31:0] ram [64];
    tilelink_a   stub_cap = '0;
    int          stub_cnt = 0;
    tilelink_d   stub_pend = '0;

    always @(negedge clock) stub_cap = mem_a;

    initial begin : stub
        tilelink_d nd;
        tilelink_d rsp;
        logic [5:0] idx;
        int k;
        mem_d = '0;
        forever begin
            @(posedge clock);
            #1;
            nd = '0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) nd = stub_pend;
            end
            if (stub_cap.a_valid === 1'b1) begin
                k = kind(stub_cap.a_address);
                if (k != 2) begin
                    idx = stub_cap.a_address[7:2];
                    ram[idx] = merge(ram[idx], stub_cap);
                    rsp = '0;
                    rsp.d_valid = 1'b1;
                    rsp.d_data = ram[idx];
                    rsp.d_opcode = (stub_cap.a_opcode == TlGet) ? TlAccessAckData : TlAccessAck;
                    if (k == 0) begin
                        nd = rsp;
                    end else begin
                        stub_pend = rsp;
                        stub_cnt = Tmo - 1;
                    end
                end
            end
            mem_d = nd;
        end
    end

    // Reference model: at most one outstanding transaction, aged in cycles since acceptance
    bit          m_busy = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    int          m_age = 0;
    logic [31:0] m_mem [64];
    logic [31:0] m_exp_data = '0;
    logic [2:0]  m_exp_op = '0;

    always @(negedge clock) begin : model
        tilelink_d  e0;
        tilelink_d  e1;
        tilelink_d  er;
        tilelink_a  sel_a;
        bit         resp_now;
        bit         tmo_now;
        bit         any;
        bit         win;
        logic [5:0] idx;
        e0 = '0; e1 = '0; er = '0; sel_a = '0;
        resp_now = 1'b0; tmo_now = 1'b0; any = 1'b0; win = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_age = 0;
            chk1("rst_h0_error", h0_d.d_error, 1'b0);
            chk1("rst_h1_error", h1_d.d_error, 1'b0);
        end else begin
            resp_now = m_busy && (mem_d.d_valid === 1'b1);
            tmo_now  = m_busy && !resp_now && (m_age == Tmo);
            if (resp_now || tmo_now) begin
                er.d_valid  = 1'b1;
                er.d_opcode = tmo_now ? TlAccessAckData : m_exp_op;
                er.d_data   = tmo_now ? 32'h0 : m_exp_data;
                er.d_error  = tmo_now;
                if (m_owner) e1 = er;
                else e0 = er;
            end
            if (!m_busy || resp_now) begin
                if (h0_a.a_valid && h1_a.a_valid) begin
                    any = 1'b1; win = !m_last;
                end else if (h0_a.a_valid || h1_a.a_valid) begin
                    any = 1'b1; win = h1_a.a_valid;
                end
            end
            sel_a = win ? h1_a : h0_a;
        end
        chk1("h0_d_ready", h0_d.d_ready, any && !win);
        chk1("h1_d_ready", h1_d.d_ready, any && win);
        chk1("mem_a_valid", mem_a.a_valid, any);
        chk1("h0_d_valid", h0_d.d_valid, e0.d_valid);
        chk1("h1_d_valid", h1_d.d_valid, e1.d_valid);
        if (e0.d_valid) begin
            chk32("h0_d_data", h0_d.d_data, e0.d_data);
            chk32("h0_d_opcode", 32'(h0_d.d_opcode), 32'(e0.d_opcode));
            chk1("h0_d_error", h0_d.d_error, e0.d_error);
        end
        if (e1.d_valid) begin
            chk32("h1_d_data", h1_d.d_data, e1.d_data);
            chk32("h1_d_opcode", 32'(h1_d.d_opcode), 32'(e1.d_opcode));
            chk1("h1_d_error", h1_d.d_error, e1.d_error);
        end
        if (any) begin
            chk32("mem_a_address", mem_a.a_address, sel_a.a_address);
            chk32("mem_a_data", mem_a.a_data, sel_a.a_data);
            chk32("mem_a_opcode", 32'(mem_a.a_opcode), 32'(sel_a.a_opcode));
            chk32("mem_a_mask", 32'(mem_a.a_mask), 32'(sel_a.a_mask));
            m_busy = 1'b1; m_owner = win; m_last = win; m_age = 1;
            if (kind(sel_a.a_address) != 2) begin
                idx = sel_a.a_address[7:2];
                m_exp_data = merge(m_mem[idx], sel_a);
                m_mem[idx] = m_exp_data;
                m_exp_op = (sel_a.a_opcode == TlGet) ? TlAccessAckData : TlAccessAck;
            end
        end else if (resp_now || tmo_now) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_age++;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_host(input int h, input tilelink_a t);
        if (h == 0) h0_a = t;
        else h1_a = t;
    endtask

    task automatic wait_accept(input int h);
        int waited = 0;
        forever begin
            @(negedge clock);
            if (((h == 0) ? h0_d.d_ready : h1_d.d_ready) === 1'b1) break;
            waited++;
            if (waited > 200) begin
                n_checks++; n_errors++;
                $display("FAIL accept_wait host=%0d actual=no_grant required=grant", h);
                break;
            end
        end
    endtask

    function automatic tilelink_a rand_req();
        int r = $urandom_range(0, 99);
        int o = $urandom_range(0, 2);
        logic [31:0] a;
        logic [3:0] m = 4'hF;
        logic [2:0] op = (o == 0) ? TlGet : ((o == 1) ? TlPutFullData : TlPutPartialData);
        a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        if (r < 4) a = 32'h40000000 | a;
        else if (r < 8) a = 32'h80000000 | a;
        if (op == TlPutPartialData) begin
            a[1:0] = 2'($urandom_range(0, 3));
            m = 4'($urandom_range(1, 15));
        end
        return mk(op, a, m, $urandom);
    endfunction

    task automatic host_drv(input int h, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) cyc();
            set_host(h, rand_req());
            w = 0;
            forever begin
                @(negedge clock);
                if (((h == 0) ? h0_d.d_ready : h1_d.d_ready) === 1'b1) break;
                if ($urandom_range(0, 31) == 0) break;
                w++;
                if (w > 200) begin
                    n_checks++; n_errors++;
                    $display("FAIL rand_accept host=%0d actual=no_grant required=grant", h);
                    break;
                end
            end
            cyc();
            set_host(h, '0);
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        h0_a = '0;
        h1_a = '0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = init_word(6'(i));
            m_mem[i] = init_word(6'(i));
        end
        // Single request, raised while reset is still high
        repeat (2) cyc();
        h0_a = mk(TlGet, 32'h10, 4'hF, 32'h0);
        @(negedge clock);
        chk1("rst_h0_ready", h0_d.d_ready, 1'b0);
        chk1("rst_mem_valid", mem_a.a_valid, 1'b0);
        chk1("rst_h0_valid", h0_d.d_valid, 1'b0);
        cyc();
        reset = 1'b0;
        @(negedge clock);
        chk1("single_gnt", h0_d.d_ready, 1'b1);
        chk1("single_mem_valid", mem_a.a_valid, 1'b1);
        chk32("single_mem_addr", mem_a.a_address, 32'h10);
        chk1("single_h1_quiet", h1_d.d_valid, 1'b0);
        cyc();
        h0_a = '0;
        @(negedge clock);
        chk1("single_rsp_valid", h0_d.d_valid, 1'b1);
        chk32("single_rsp_data", h0_d.d_data, 32'hDEADBEEF);
        chk1("single_h1_quiet2", h1_d.d_valid, 1'b0);

        // Contention after a fresh reset: grants 0,1,0,1 and one response per cycle
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        h0_a = mk(TlGet, 32'h10, 4'hF, 32'h0);
        h1_a = mk(TlGet, 32'h20, 4'hF, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i < 4) begin
                chk1("cont_gnt", (i % 2 == 0) ? h0_d.d_ready : h1_d.d_ready, 1'b1);
                chk1("cont_other", (i % 2 == 0) ? h1_d.d_ready : h0_d.d_ready, 1'b0);
            end
            if (i > 0) begin
                chk1("cont_rsp", (i % 2 == 1) ? h0_d.d_valid : h1_d.d_valid, 1'b1);
                chk1("cont_rsp_other", (i % 2 == 1) ? h1_d.d_valid : h0_d.d_valid, 1'b0);
                chk32("cont_rsp_data", (i % 2 == 1) ? h0_d.d_data : h1_d.d_data,
                      (i % 2 == 1) ? 32'hDEADBEEF : 32'h11223344);
            end
            cyc();
            if (i == 3) begin
                h0_a = '0;
                h1_a = '0;
            end
        end

        // Partial write then read-back of the same word
        h1_a = mk(TlPutPartialData, 32'h21, 4'b0010, 32'h000000AB);
        wait_accept(1);
        cyc(); h1_a = '0;
        @(negedge clock);
        chk1("ppd_rsp_valid", h1_d.d_valid, 1'b1);
        chk32("ppd_rsp_data", h1_d.d_data, 32'h1122AB44);
        h0_a = mk(TlGet, 32'h20, 4'hF, 32'h0);
        wait_accept(0);
        cyc(); h0_a = '0;
        @(negedge clock);
        chk32("ppd_readback", h0_d.d_data, 32'h1122AB44);

        // Tag miss: error exactly Tmo cycles after acceptance, waiting host granted next cycle
        cyc();
        h0_a = mk(TlGet, 32'h40000000, 4'hF, 32'h0);
        wait_accept(0);
        cyc(); h0_a = '0;
        h1_a = mk(TlGet, 32'h10, 4'hF, 32'h0);
        for (int k = 1; k <= Tmo + 1; k++) begin
            @(negedge clock);
            chk1("miss_h0_valid", h0_d.d_valid, k == Tmo);
            if (k <= Tmo) chk1("miss_h1_held", h1_d.d_ready, 1'b0);
            if (k == Tmo) begin
                chk1("miss_error", h0_d.d_error, 1'b1);
                chk32("miss_data", h0_d.d_data, 32'h0);
            end
            if (k == Tmo + 1) chk1("miss_h1_gnt", h1_d.d_ready, 1'b1);
        end
        cyc(); h1_a = '0;

        // Reset during the response cycle: response dropped, host 0 wins afterwards
        cyc();
        h0_a = mk(TlGet, 32'h10, 4'hF, 32'h0);
        wait_accept(0);
        cyc(); h0_a = '0; reset = 1'b1;
        @(negedge clock);
        chk1("rstmid_ram_answered", mem_d.d_valid, 1'b1);
        chk1("rstmid_h0_valid", h0_d.d_valid, 1'b0);
        chk1("rstmid_h1_valid", h1_d.d_valid, 1'b0);
        cyc(); reset = 1'b0;
        h0_a = mk(TlGet, 32'h20, 4'hF, 32'h0);
        h1_a = mk(TlGet, 32'h10, 4'hF, 32'h0);
        @(negedge clock);
        chk1("rstmid_h0_first", h0_d.d_ready, 1'b1);
        chk1("rstmid_h1_waits", h1_d.d_ready, 1'b0);
        cyc(); h0_a = '0;
        wait_accept(1);
        cyc(); h1_a = '0;

        // Real answer in the same cycle the timeout would fire
        repeat (3) cyc();
        h0_a = mk(TlGet, 32'h80000010, 4'hF, 32'h0);
        wait_accept(0);
        cyc(); h0_a = '0;
        for (int k = 1; k <= Tmo + 2; k++) begin
            @(negedge clock);
            chk1("bnd_valid", h0_d.d_valid, k == Tmo);
            if (k == Tmo) begin
                chk1("bnd_error", h0_d.d_error, 1'b0);
                chk32("bnd_data", h0_d.d_data, 32'hDEADBEEF);
            end
        end

        // Random traffic from both hosts
        fork
            host_drv(0, 150);
            host_drv(1, 150);
        join
        h0_a = '0;
        h1_a = '0;
        repeat (3 * Tmo) cyc();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
